// File: rtl/fc_pkg.sv
// fc_pkg: shared constants, logit limits and head FSM encoding
package fc_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 14;
  localparam int N_CLASS = 10;
  localparam int IDX_W = 4;
  localparam logic [DATA_W-1:0] LOGIT_MAX = 16'h7fff;
  localparam logic [DATA_W-1:0] LOGIT_MIN = 16'h8000;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/sat_add16.sv
// sat_add16: signed 16+16 add, overflow caught at 17 bits and clamped
module sat_add16
  import fc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  logic [DATA_W:0] s;
  // Overflow whenever the two top bits of the widened sum disagree
  always_comb begin
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    y = (s[DATA_W] != s[DATA_W-1]) ? (s[DATA_W] ? LOGIT_MIN : LOGIT_MAX) : s[DATA_W-1:0];
  end
endmodule

// File: rtl/fc10_argmax.sv
// fc10_argmax: bias-add and sequential argmax over ten FC logits with valid/ready result
module fc10_argmax
  import fc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     finish,
  input  logic [N_CLASS*DATA_W-1:0] psum,
  input  logic [N_CLASS*DATA_W-1:0] bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         class_idx,
  output logic [DATA_W-1:0]        max_val,
  output logic                     busy,
  output logic                     overrun
);
  state_t state;
  logic fin_d;
  logic start;
  logic [IDX_W-1:0] cnt;
  logic [DATA_W-1:0] logit [N_CLASS];
  logic [DATA_W-1:0] sum [N_CLASS];
  assign start = finish & ~fin_d;
  for (genvar k = 0; k < N_CLASS; k++) begin : g_sat
    sat_add16 u_sat (
      .a(psum[k*DATA_W +: DATA_W]),
      .b(bias[k*DATA_W +: DATA_W]),
      .y(sum[k])
    );
  end
  // Capture on start, scan one logit per cycle, hold result until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      fin_d <= 1'b0;
      cnt <= '0;
      for (int i = 0; i < N_CLASS; i++) logit[i] <= '0;
      out_valid <= 1'b0;
      class_idx <= '0;
      max_val <= '0;
      busy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      fin_d <= finish;
      overrun <= start && state != IDLE;
      case (state)
        IDLE: if (start) begin
          for (int i = 0; i < N_CLASS; i++) logit[i] <= sum[i];
          max_val <= sum[0];
          class_idx <= '0;
          cnt <= IDX_W'(1);
          busy <= 1'b1;
          state <= SCAN;
        end
        SCAN: begin
          if ($signed(logit[cnt]) > $signed(max_val)) begin
            max_val <= logit[cnt];
            class_idx <= cnt;
          end
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(N_CLASS-1)) begin
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fc10_argmax.md
# fc10_argmax

Classification head placed directly downstream of the 1×64 · 64×10 fully-connected stage. On each rising edge of that stage's `finish`, it performs three steps. First, it captures the ten signed 16-bit partial sums. Second, it adds a per-class bias with saturation. Third, it scans the ten logits sequentially to find the winning class. The class index and its logit are presented on a valid/ready output to the result sink (UART/host register bank).

## Interface
- `DATA_W`, 16: logit width, two's complement, 14 fractional bits; 0x0200 = 0.03125.
- `N_CLASS`, 10: number of classes.
- `IDX_W`, 4: class index width, equal to clog2(N_CLASS).
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `finish`, input, 1: done flag from the FC stage; may be a level or a pulse; only its rising edge is used.
- `psum`, input, N_CLASS*DATA_W (160): FC outputs; class k is `psum[16k+15:16k]`, so class 0 is at the LSBs.
- `bias`, input, N_CLASS*DATA_W (160): per-class bias with the same packing; static, sampled together with `psum`.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: sink accepts the result.
- `class_idx`, output, IDX_W: index of the maximum logit.
- `max_val`, output, DATA_W: saturated biased logit of the winning class.
- `busy`, output, 1: high in SCAN or DONE.
- `overrun`, output, 1: one-cycle pulse when a `finish` rising edge is dropped.

## Operation
- FSM states: IDLE, SCAN, DONE.
- **Edge detect:** `fin_d` is registered from `finish`; `start = finish & ~fin_d`.
- **IDLE, on `start`:**
  - For each k, `logit[k] <= sat(psum_k + bias_k)`. The sum is taken at 17 bits and clamped to [0x8000, 0x7FFF].
  - `best_val <= logit0`, `best_idx <= 0`, `cnt <= 1`, then go to SCAN.
- **SCAN, each cycle:**
  - If `logit[cnt] > best_val` (signed, strict), then `best_val <= logit[cnt]` and `best_idx <= cnt`.
  - Ties keep the lower index.
  - `cnt <= cnt+1`. On the cycle with `cnt == N_CLASS-1`, go to DONE.
- **DONE:**
  - `out_valid = 1`.
  - `class_idx`/`max_val` are held stable until `out_valid & out_ready`, then return to IDLE.
- **Dropped start:** a `start` seen in SCAN or DONE is ignored, pulses `overrun`, and leaves the captured data untouched.
- **Start on the acceptance cycle:** a `start` in the same cycle as DONE acceptance is also dropped, with `overrun` pulsed.
- **Reset values (`rst` low, asynchronous):**
  - state = IDLE, `fin_d` = 0, `cnt` = 0, all logit registers = 0.
  - Outputs: `out_valid` = 0, `class_idx` = 0, `max_val` = 0x0000, `busy` = 0, `overrun` = 0.
  - Reset mid-SCAN or mid-DONE abandons the result.
- **`finish` held high through reset:** `fin_d` = 0 after reset, so a level-high `finish` yields exactly one `start` on the first edge after reset release.

## Timing
- **Latency:** `start` is sampled at edge E0. Compares happen at edges E1..E9. `out_valid` rises after E9, i.e. N_CLASS−1 = 9 cycles after capture.
- **Throughput:** at most one result per N_CLASS cycles plus the handshake cycle.
- **Handshake:** `out_valid` never drops without `out_ready`. Acceptance takes one cycle, and IDLE is re-entered at the next edge.
- **Backpressure:** `out_ready` is ignored outside DONE.
- **`busy`:** registered, asserted from E0 through the acceptance edge.
- **`overrun`:** registered, high for exactly the cycle after the dropped `start` edge.
- **Combinational paths:** none from input to output.

## Structure
- Shared package `fc_pkg`:
  - Constants `DATA_W`, `FRAC_W`=14, `N_CLASS`, `IDX_W`.
  - Min/max limits `LOGIT_MAX`=0x7FFF and `LOGIT_MIN`=0x8000.
  - State encoding for IDLE/SCAN/DONE.
- Sub-module `sat_add16`: combinational 16+16 signed add with 17-bit detect and clamp. It is instantiated N_CLASS times at the capture stage.
- The comparator and index counter are inline. The logit registers form a 10×16 array read by `cnt`.

## Test plan
- **Uniform input:** all `psum` lanes 0x0200, `bias` 0 → `class_idx`=0, `max_val`=0x0200 (tie resolves low); `out_valid` rises 9 cycles after the `start` edge.
- **Max at top lane:** `psum` lane k = 0x0100·k, `bias` 0 → `class_idx`=9, `max_val`=0x0900. Then reverse the order → `class_idx`=0.
- **Saturation and negatives:**
  - Lane 3 = 0x7F00 with bias 0x0200 → saturates to 0x7FFF, wins `class_idx`=3.
  - All lanes 0xFF00 except lane 7 = 0xFFF0 → `class_idx`=7, `max_val`=0xFFF0.
  - Lane 0 = 0x8100 with bias 0x8000 → 0x8000.
- **Backpressure:** hold `out_ready`=0 for 20 cycles → outputs stable and `busy`=1. Then set `out_ready`=1 → accepted in one cycle and IDLE re-entered.
- **Overrun:** pulse `finish` again at cycle 4 of SCAN and again during DONE → `overrun` pulses twice, and the first result is unchanged.
- **Reset and level `finish`:** assert `rst` low mid-SCAN → all outputs 0 immediately, no `out_valid`. Release `rst` with `finish` held high → exactly one result produced.
